// File: rtl/board_material_evaluator_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : board_material_evaluator_pkg
// Shared chess types, piece-plane indices, default values and score select.
// Revision : 1.0
// ----------------------------------------------------------------------------
package board_material_evaluator_pkg;

  localparam int NUM_PLANES = 5;

  localparam int PIECE_KNIGHT = 0;
  localparam int PIECE_BISHOP = 1;
  localparam int PIECE_ROOK   = 2;
  localparam int PIECE_QUEEN  = 3;
  localparam int PIECE_PAWN   = 4;

  localparam int DEFAULT_VAL_KNIGHT = 320;
  localparam int DEFAULT_VAL_BISHOP = 330;
  localparam int DEFAULT_VAL_ROOK   = 500;
  localparam int DEFAULT_VAL_QUEEN  = 900;
  localparam int DEFAULT_VAL_PAWN   = 100;
  localparam int DEFAULT_MATE_SCORE = 30000;

  typedef logic [5:0]         coord_t;
  typedef logic signed [15:0] score_t;

  typedef struct packed {
    logic [NUM_PLANES-1:0][63:0] planes;
    logic [63:0]                 pieces_w;
    coord_t                      king_w;
    coord_t                      king_b;
    logic [1:0]                  checkmate;
    logic [7:0]                  ply50;
  } board_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Mate flags outrank the 50-move draw, which outranks material.
  function automatic score_t select_score(input board_t b, input score_t acc,
                                          input score_t mate);
    score_t result;
    if (b.checkmate == 2'b11)   result = '0;
    else if (b.checkmate[1])    result = mate;
    else if (b.checkmate[0])    result = -mate;
    else if (b.ply50 >= 8'd100) result = '0;
    else                        result = acc;
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/board_material_evaluator_square_chunk_scorer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : board_material_evaluator_square_chunk_scorer
// Combinational signed material sum over one slice of squares.
// Revision : 1.0
// ----------------------------------------------------------------------------
module board_material_evaluator_square_chunk_scorer
  import board_material_evaluator_pkg::*;
#(
  parameter int SQ_PER_CYCLE = 8,
  parameter int VAL_KNIGHT   = DEFAULT_VAL_KNIGHT,
  parameter int VAL_BISHOP   = DEFAULT_VAL_BISHOP,
  parameter int VAL_ROOK     = DEFAULT_VAL_ROOK,
  parameter int VAL_QUEEN    = DEFAULT_VAL_QUEEN,
  parameter int VAL_PAWN     = DEFAULT_VAL_PAWN
) (
  input  logic [NUM_PLANES-1:0][SQ_PER_CYCLE-1:0] plane_slice,
  input  logic [SQ_PER_CYCLE-1:0]                 white_slice,
  output score_t                                  chunk_sum
);

  localparam score_t c_values [NUM_PLANES] = '{
    score_t'(VAL_KNIGHT), score_t'(VAL_BISHOP), score_t'(VAL_ROOK),
    score_t'(VAL_QUEEN),  score_t'(VAL_PAWN)
  };

  score_t w_sum;

  // Overlapping planes on one square simply accumulate; no legality check.
  always_comb begin
    w_sum = '0;
    for (int s = 0; s < SQ_PER_CYCLE; s++) begin
      for (int p = 0; p < NUM_PLANES; p++) begin
        if (plane_slice[p][s]) begin
          if (white_slice[s]) w_sum = w_sum + c_values[p];
          else                w_sum = w_sum - c_values[p];
        end
      end
    end
  end

  assign chunk_sum = w_sum;

endmodule
`default_nettype wire

// File: rtl/board_material_evaluator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : board_material_evaluator
// Multi-cycle White-perspective material scorer with mate/50-move overrides.
// Revision : 1.0
// ----------------------------------------------------------------------------
module board_material_evaluator
  import board_material_evaluator_pkg::*;
#(
  parameter int SQ_PER_CYCLE = 8,
  parameter int VAL_KNIGHT   = DEFAULT_VAL_KNIGHT,
  parameter int VAL_BISHOP   = DEFAULT_VAL_BISHOP,
  parameter int VAL_ROOK     = DEFAULT_VAL_ROOK,
  parameter int VAL_QUEEN    = DEFAULT_VAL_QUEEN,
  parameter int VAL_PAWN     = DEFAULT_VAL_PAWN,
  parameter int MATE_SCORE   = DEFAULT_MATE_SCORE
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  board_t board_in,
  input  logic   captured_in,
  input  logic   valid_in,
  output logic   ready_out,
  output board_t board_out,
  output logic   captured_out,
  output score_t score_out,
  output logic   valid_out,
  input  logic   ready_in
);

  localparam int NCHUNK  = 64 / SQ_PER_CYCLE;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  board_t             r_board;
  logic               r_captured;
  score_t             r_acc;
  score_t             r_score;
  logic [CHUNK_W-1:0] r_chunk;

  logic [5:0]                             w_base;
  logic                                   w_last;
  logic [NUM_PLANES-1:0][SQ_PER_CYCLE-1:0] w_plane_slice;
  logic [SQ_PER_CYCLE-1:0]                 w_white_slice;
  score_t                                 w_chunk_sum;
  score_t                                 w_acc_next;

  assign w_base     = 6'(int'(r_chunk) * SQ_PER_CYCLE);
  assign w_last     = (r_chunk == CHUNK_W'(NCHUNK - 1));
  assign w_acc_next = r_acc + w_chunk_sum;

  always_comb begin
    for (int p = 0; p < NUM_PLANES; p++) begin
      w_plane_slice[p] = r_board.planes[p][w_base +: SQ_PER_CYCLE];
    end
    w_white_slice = r_board.pieces_w[w_base +: SQ_PER_CYCLE];
  end

  board_material_evaluator_square_chunk_scorer #(
    .SQ_PER_CYCLE (SQ_PER_CYCLE),
    .VAL_KNIGHT   (VAL_KNIGHT),
    .VAL_BISHOP   (VAL_BISHOP),
    .VAL_ROOK     (VAL_ROOK),
    .VAL_QUEEN    (VAL_QUEEN),
    .VAL_PAWN     (VAL_PAWN)
  ) u_square_chunk_scorer (
    .plane_slice (w_plane_slice),
    .white_slice (w_white_slice),
    .chunk_sum   (w_chunk_sum)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (valid_in) w_next_state = ST_SCAN;
      ST_SCAN: if (w_last)   w_next_state = ST_DONE;
      ST_DONE: if (ready_in) w_next_state = ST_IDLE;
      default:               w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_out = (r_state == ST_IDLE);
    valid_out = (r_state == ST_DONE);
  end

  // The final score is resolved on the last scan edge so DONE holds a stable register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_board    <= '0;
      r_captured <= 1'b0;
      r_acc      <= '0;
      r_score    <= '0;
      r_chunk    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_board    <= board_in;
            r_captured <= captured_in;
            r_acc      <= '0;
            r_chunk    <= '0;
          end
        end
        ST_SCAN: begin
          r_acc   <= w_acc_next;
          r_chunk <= r_chunk + 1'b1;
          if (w_last) r_score <= select_score(r_board, w_acc_next, score_t'(MATE_SCORE));
        end
        default: ;
      endcase
    end
  end

  assign board_out    = r_board;
  assign captured_out = r_captured;
  assign score_out    = r_score;

endmodule
`default_nettype wire

// File: tb/tb_board_material_evaluator.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_board_material_evaluator
// Directed scoreboard bench for the board material evaluator.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_board_material_evaluator;
  import board_material_evaluator_pkg::*;

  typedef struct packed {
    score_t score;
    board_t board;
    logic   captured;
  } exp_t;

  logic   clk_in = 1'b0;
  logic   rst_in;
  board_t board_in;
  logic   captured_in;
  logic   valid_in;
  logic   ready_out;
  board_t board_out;
  logic   captured_out;
  score_t score_out;
  logic   valid_out;
  logic   ready_in;

  exp_t sb [$];
  int   n_assert = 0;
  int   n_fail   = 0;

  board_material_evaluator dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .board_in     (board_in),
    .captured_in  (captured_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .board_out    (board_out),
    .captured_out (captured_out),
    .score_out    (score_out),
    .valid_out    (valid_out),
    .ready_in     (ready_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic score_t model(input board_t b);
    int vals [5] = '{320, 330, 500, 900, 100};
    int acc = 0;
    for (int s = 0; s < 64; s++)
      for (int p = 0; p < 5; p++)
        if (b.planes[p][s]) acc += b.pieces_w[s] ? vals[p] : -vals[p];
    if (b.checkmate == 2'b11) return 16'sd0;
    if (b.checkmate == 2'b10) return 16'sd30000;
    if (b.checkmate == 2'b01) return -16'sd30000;
    if (b.ply50 >= 8'd100)    return 16'sd0;
    return score_t'(acc);
  endfunction

  function automatic board_t start_pos();
    board_t b = '0;
    b.planes[PIECE_KNIGHT] = 64'h4200_0000_0000_0042;
    b.planes[PIECE_BISHOP] = 64'h2400_0000_0000_0024;
    b.planes[PIECE_ROOK]   = 64'h8100_0000_0000_0081;
    b.planes[PIECE_QUEEN]  = 64'h0800_0000_0000_0008;
    b.planes[PIECE_PAWN]   = 64'h00FF_0000_0000_FF00;
    b.pieces_w             = 64'h0000_0000_0000_FFFF;
    b.king_w               = 6'd4;
    b.king_b               = 6'd60;
    return b;
  endfunction

  task automatic push_exp(input board_t b, input logic cap);
    exp_t e;
    e.score    = model(b);
    e.board    = b;
    e.captured = cap;
    sb.push_back(e);
  endtask

  // Present a board and hold valid_in until the DUT takes it.
  task automatic send(input board_t b, input logic cap);
    board_in    = b;
    captured_in = cap;
    valid_in    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (ready_out) begin
        @(posedge clk_in); #1;
        push_exp(b, cap);
        valid_in = 1'b0;
        return;
      end
      @(posedge clk_in); #1;
    end
    chk("send_timeout", 512'(ready_out), 512'(1'b1));
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !valid_out; i++) begin
      @(posedge clk_in); #1;
    end
    if (!valid_out) chk({tag, "_timeout"}, 512'(valid_out), 512'(1'b1));
  endtask

  // Compare the head of the scoreboard, stall for hold cycles, then handshake.
  task automatic drain(input string tag, input int hold);
    exp_t e;
    wait_valid(tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 512'(sb.size()), 512'(1));
      return;
    end
    e = sb.pop_front();
    chk({tag, "_score"},    512'(score_out),    512'(e.score));
    chk({tag, "_board"},    512'(board_out),    512'(e.board));
    chk({tag, "_captured"}, 512'(captured_out), 512'(e.captured));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_in); #1;
      chk({tag, "_hold_valid"}, 512'(valid_out), 512'(1'b1));
      chk({tag, "_hold_score"}, 512'(score_out), 512'(e.score));
      chk({tag, "_hold_ready"}, 512'(ready_out), 512'(1'b0));
    end
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    chk({tag, "_post_valid"}, 512'(valid_out), 512'(1'b0));
    chk({tag, "_post_ready"}, 512'(ready_out), 512'(1'b1));
  endtask

  initial begin
    board_t b;
    board_t b2;

    rst_in      = 1'b0;
    board_in    = '0;
    captured_in = 1'b0;
    valid_in    = 1'b0;
    ready_in    = 1'b0;
    #12;
    chk("rst_valid",    512'(valid_out),    512'(1'b0));
    chk("rst_ready",    512'(ready_out),    512'(1'b1));
    chk("rst_score",    512'(score_out),    512'(16'sd0));
    chk("rst_captured", 512'(captured_out), 512'(1'b0));
    chk("rst_board",    512'(board_out),    512'(0));
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Start position: valid_out rises on the 9th edge counting the accept edge.
    send(start_pos(), 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_in); #1;
      chk($sformatf("latency_edge%0d", i + 1), 512'(valid_out), 512'(i == 8));
    end
    drain("startpos", 0);

    b = start_pos();
    b.planes[PIECE_QUEEN][59] = 1'b0;
    send(b, 1'b1);
    drain("no_black_queen", 0);

    b = '0;
    b.king_w = 6'd4;
    b.king_b = 6'd60;
    b.planes[PIECE_PAWN][52] = 1'b1;
    send(b, 1'b0);
    drain("lone_black_pawn", 0);

    b = start_pos();
    b.planes[PIECE_ROOK][0] = 1'b0;
    b.checkmate = 2'b10;
    send(b, 1'b1);
    drain("black_king_taken", 0);

    b = '0;
    b.planes[PIECE_ROOK][0] = 1'b1;
    b.pieces_w[0] = 1'b1;
    b.ply50 = 8'd100;
    send(b, 1'b0);
    drain("ply50_draw", 0);

    b = start_pos();
    b.checkmate = 2'b11;
    send(b, 1'b1);
    drain("both_kings_taken", 0);

    b = start_pos();
    b.planes[PIECE_PAWN][55] = 1'b0;
    b.checkmate = 2'b01;
    send(b, 1'b1);
    drain("white_king_taken_bp", 5);

    // Abort at chunk 4; score_out still holds -30000 from the previous board.
    b = start_pos();
    b.planes[PIECE_QUEEN][3] = 1'b0;
    send(b, 1'b1);
    void'(sb.pop_back());
    repeat (4) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b0;
    #1;
    chk("abort_valid",    512'(valid_out),    512'(1'b0));
    chk("abort_ready",    512'(ready_out),    512'(1'b1));
    chk("abort_score",    512'(score_out),    512'(16'sd0));
    chk("abort_captured", 512'(captured_out), 512'(1'b0));
    #2;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    b = start_pos();
    b.planes[PIECE_PAWN][48] = 1'b0;
    send(b, 1'b0);
    drain("after_abort", 0);

    // Back-to-back with valid_in held high across both boards.
    b = start_pos();
    b.planes[PIECE_KNIGHT][1] = 1'b0;
    b2 = start_pos();
    b2.planes[PIECE_ROOK][63] = 1'b0;
    board_in    = b;
    captured_in = 1'b0;
    valid_in    = 1'b1;
    @(posedge clk_in); #1;
    push_exp(b, 1'b0);
    board_in    = b2;
    captured_in = 1'b1;
    wait_valid("b2b_first");
    chk("b2b_first_score",    512'(score_out),    512'(model(b)));
    chk("b2b_first_captured", 512'(captured_out), 512'(1'b0));
    chk("b2b_ready_in_done",  512'(ready_out),    512'(1'b0));
    void'(sb.pop_front());
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    chk("b2b_gap_valid", 512'(valid_out), 512'(1'b0));
    chk("b2b_gap_ready", 512'(ready_out), 512'(1'b1));
    @(posedge clk_in); #1;
    push_exp(b2, 1'b1);
    valid_in = 1'b0;
    chk("b2b_second_taken", 512'(ready_out), 512'(1'b0));
    drain("b2b_second", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
